// File: rtl/sat_add_arbiter.sv
// Purpose : round-robin arbiter sharing one signed saturating adder among N_REQ requesters.
// Latency : 1 cycle from an accepted request to res_vld; 1 result/cycle with res_rdy held high.
// Backpr. : when the output stage is held (res_vld && !res_rdy) every req_rdy bit is 0.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   req_vld/req_rdy per-requester valid / grant (req_rdy one-hot or zero)
//   req_a/req_b     packed operands, requester i at [i*W +: W]
//   res_vld/res_rdy result handshake
//   res_id          requester index that produced the result
//   res_sum/res_sat saturated sum and clamp flag
//   sat_cnt         (only with SAT_ADD_ARB_SAT_CNT_EN) count of accepted saturated results,
//                   sticks at 16'hFFFF
module sat_add_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int W     = 4,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_vld,
  output logic [N_REQ-1:0]   req_rdy,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic               res_vld,
  input  logic               res_rdy,
  output logic [ID_W-1:0]    res_id,
  output logic [W-1:0]       res_sum,
  output logic               res_sat
`ifdef SAT_ADD_ARB_SAT_CNT_EN
  ,
  output logic [15:0]        sat_cnt
`endif
);

  // Exact-sum bounds at W+2 bits: +2^(W-1)-1 and -2^(W-1).
  localparam logic signed [W+1:0] SUM_MAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SUM_MIN = {3'b111, {(W-1){1'b0}}};
  localparam logic [W-1:0]        RES_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]        RES_MIN = {1'b1, {(W-1){1'b0}}};

  logic [ID_W-1:0]    ptr;
  logic               stage_free;
  logic               gnt_any;
  logic [ID_W-1:0]    gnt_idx;
  logic [W-1:0]       op_a;
  logic [W-1:0]       op_b;
  logic signed [W+1:0] sum_ext;
  logic [W-1:0]       sum_clamped;
  logic               sum_sat;

  // The stage can take a new result if it is empty or its current
  // result leaves this cycle.
  assign stage_free = !res_vld || res_rdy;

  // Round-robin search starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    op_a    = '0;
    op_b    = '0;
    req_rdy = '0;
    if (stage_free) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!gnt_any && req_vld[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = ID_W'(idx);
          op_a    = req_a[idx*W +: W];
          op_b    = req_b[idx*W +: W];
        end
      end
    end
    req_rdy[gnt_idx] = gnt_any;
  end

  // Two guard bits make the addition exact, so clamping is a plain compare.
  always_comb begin
    sum_ext     = {{2{op_a[W-1]}}, op_a} + {{2{op_b[W-1]}}, op_b};
    sum_clamped = sum_ext[W-1:0];
    sum_sat     = 1'b0;
    if (sum_ext > SUM_MAX) begin
      sum_clamped = RES_MAX;
      sum_sat     = 1'b1;
    end else if (sum_ext < SUM_MIN) begin
      sum_clamped = RES_MIN;
      sum_sat     = 1'b1;
    end
  end

  // Output stage and pointer. A new grant always overwrites the stage
  // (it only happens when the stage is free), so load-and-drain in the
  // same cycle yields no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld <= 1'b0;
      res_id  <= '0;
      res_sum <= '0;
      res_sat <= 1'b0;
      ptr     <= '0;
    end else if (gnt_any) begin
      res_vld <= 1'b1;
      res_id  <= gnt_idx;
      res_sum <= sum_clamped;
      res_sat <= sum_sat;
      if (gnt_idx == ID_W'(N_REQ - 1)) ptr <= '0;
      else                             ptr <= gnt_idx + ID_W'(1);
    end else if (res_rdy) begin
      res_vld <= 1'b0;
    end
  end

`ifdef SAT_ADD_ARB_SAT_CNT_EN
  // Counts saturated results as they leave the stage, not as they enter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (res_vld && res_rdy && res_sat && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Testbench for sat_add_arbiter: randomized + directed stimulus, scoreboard checking
// against a behavioural model (arbitration from a rotating priority index, sum from
// integer arithmetic with clamping). Build with SAT_ADD_ARB_SAT_CNT_EN to cover sat_cnt.
module tb_sat_add_arbiter;
  localparam int N   = 4;
  localparam int W   = 4;
  localparam int IDW = $clog2(N);

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_vld;
  logic [N-1:0]     req_rdy;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic             res_vld;
  logic             res_rdy;
  logic [IDW-1:0]   res_id;
  logic [W-1:0]     res_sum;
  logic             res_sat;
`ifdef SAT_ADD_ARB_SAT_CNT_EN
  logic [15:0]      sat_cnt;
`endif

  sat_add_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_id(res_id),
    .res_sum(res_sum), .res_sat(res_sat)
`ifdef SAT_ADD_ARB_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           sat;
  } res_t;

  res_t         exp_q[$];
  int           n_cmp  = 0;
  int           n_fail = 0;

  // Requester-side stimulus state
  logic [N-1:0] pend   = '0;
  logic [W-1:0] opa[N];
  logic [W-1:0] opb[N];
  logic         rdy_in = 1'b1;
  logic         rst_in = 1'b1;

  // Model state
  int           ptr     = 0;
  bit           exp_vld = 1'b0;
  int           exp_g;
  int           exp_satcnt = 0;
  logic [N-1:0] act_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic res_t ref_add(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    int   s;
    int   hi;
    int   lo;
    hi    = (1 << (W-1)) - 1;
    lo    = -(1 << (W-1));
    s     = int'($signed(a)) + int'($signed(b));
    r.id  = IDW'(id);
    r.sat = 1'b0;
    if (s > hi) begin
      s = hi; r.sat = 1'b1;
    end else if (s < lo) begin
      s = lo; r.sat = 1'b1;
    end
    r.sum = W'(s);
    return r;
  endfunction

  task automatic offer(input int i, input int a, input int b);
    pend[i] = 1'b1;
    opa[i]  = W'(a);
    opb[i]  = W'(b);
  endtask

  task automatic offer_rand(input int i);
    if (!pend[i]) offer(i, int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)));
  endtask

  // One clock cycle: apply inputs, check the grant against the model, then
  // advance the model on the rising edge.
  task automatic step();
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    if (rst_in) pend = '0;
    rst     = rst_in;
    res_rdy = rdy_in;
    for (int i = 0; i < N; i++) begin
      req_vld[i]         = pend[i];
      req_a[i*W +: W]    = opa[i];
      req_b[i*W +: W]    = opb[i];
    end
    #1;
    exp_g = -1;
    if (!rst_in && (!exp_vld || rdy_in)) begin
      for (int k = 0; k < N; k++)
        if (exp_g < 0 && pend[(ptr + k) % N]) exp_g = (ptr + k) % N;
    end
    exp_rdy = '0;
    if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
    act_rdy = req_rdy;
    check("req_rdy", 32'(req_rdy), 32'(exp_rdy));
    @(posedge clk);
    if (rst_in) begin
      ptr        = 0;
      exp_vld    = 1'b0;
      exp_satcnt = 0;
      exp_q.delete();
    end else if (exp_g >= 0) begin
      exp_q.push_back(ref_add(exp_g, opa[exp_g], opb[exp_g]));
      ptr          = (exp_g + 1) % N;
      pend[exp_g]  = 1'b0;
      exp_vld      = 1'b1;
    end else if (rdy_in) begin
      exp_vld = 1'b0;
    end
  endtask

  // Monitor: compares the presented result with the scoreboard head every
  // cycle and retires it on a handshake.
  initial begin
    res_t got;
    forever begin
      @(negedge clk);
      #2;
      if (rst !== 1'b0) continue;
      check("res_vld", 32'(res_vld), 32'(exp_q.size() > 0));
`ifdef SAT_ADD_ARB_SAT_CNT_EN
      check("sat_cnt_track", 32'(sat_cnt), 32'(exp_satcnt));
`endif
      if (res_vld === 1'b1 && exp_q.size() > 0) begin
        got = '{id: res_id, sum: res_sum, sat: res_sat};
        check("result", 32'(got), 32'(exp_q[0]));
        if (res_rdy === 1'b1) begin
          if (exp_q[0].sat && exp_satcnt < 16'hFFFF) exp_satcnt++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic drain(input int n);
    pend   = '0;
    rdy_in = 1'b1;
    repeat (n) step();
  endtask

  // Saturation table: a, b, expected sum, expected sat
  int sat_tab[7][4] = '{
    '{ 4,  7,  7, 1}, '{-4, -7, -8, 1}, '{ 3, -5, -2, 0}, '{-3, -6, -8, 1},
    '{ 4, -4,  0, 0}, '{ 7,  7,  7, 1}, '{-8, -8, -8, 1}
  };

  initial begin
    logic [W-1:0] es;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
    rst = 1'b1; res_rdy = 1'b0; req_vld = '0; req_a = '0; req_b = '0;

    // Reset
    rst_in = 1'b1; rdy_in = 1'b1;
    repeat (2) step();
    rst_in = 1'b0;
    #2;
    check("reset_vld", 32'(res_vld), 0);
    check("reset_id",  32'(res_id),  0);
    check("reset_sum", 32'(res_sum), 0);
    check("reset_sat", 32'(res_sat), 0);
`ifdef SAT_ADD_ARB_SAT_CNT_EN
    check("reset_sat_cnt", 32'(sat_cnt), 0);
`endif

    // All requesters valid: grants rotate 0,1,2,3,0,1
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) offer_rand(i);
      step();
      check("rr_order", 32'(act_rdy), 32'(1 << (c % 4)));
    end
    drain(2);

    // Saturation vectors through requester 0, counter starting from zero
    rst_in = 1'b1; step(); rst_in = 1'b0;
    for (int v = 0; v < 7; v++) begin
      offer(0, sat_tab[v][0], sat_tab[v][1]);
      step();
      #2;
      es = W'(sat_tab[v][2]);
      check("sat_sum", 32'(res_sum), 32'(es));
      check("sat_flag", 32'(res_sat), 32'(sat_tab[v][3]));
    end
    drain(2);
`ifdef SAT_ADD_ARB_SAT_CNT_EN
    check("sat_cnt_five", 32'(sat_cnt), 5);
`endif

    // Backpressure: result held for 3 cycles, grants blocked
    offer(1, 1, 2);
    step();
    offer(2, 3, 3);
    rdy_in = 1'b0;
    repeat (3) begin
      step();
      check("hold_rdy", 32'(act_rdy), 0);
      #2;
      check("hold_vld", 32'(res_vld), 1);
      check("hold_sum", 32'(res_sum), 3);
      check("hold_id",  32'(res_id),  1);
    end
    rdy_in = 1'b1;
    step();
    check("release_grant", 32'(act_rdy), 32'(1 << 2));
    drain(2);

`ifdef SAT_ADD_ARB_SAT_CNT_EN
    // A held saturating result counts only when accepted
    offer(3, 7, 7);
    step();
    rdy_in = 1'b0;
    repeat (2) step();
    #2;
    check("sat_cnt_held", 32'(sat_cnt), 5);
    rdy_in = 1'b1;
    step();
    #2;
    check("sat_cnt_accept", 32'(sat_cnt), 6);
    drain(1);
`endif

    // Only requester 2: granted every cycle
    for (int c = 0; c < 4; c++) begin
      offer_rand(2);
      step();
      check("solo_grant", 32'(act_rdy), 32'(1 << 2));
    end
    // Requesters 0 and 2 with pointer at 3: alternate 0,2,0,2
    for (int c = 0; c < 4; c++) begin
      offer_rand(0);
      offer_rand(2);
      step();
      check("skip_grant", 32'(act_rdy), (c % 2 == 0) ? 32'd1 : 32'd4);
    end
    drain(2);

    // Reset while a result is held
    offer(1, 5, 1);
    step();
    rdy_in = 1'b0;
    step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    #2;
    check("midrst_vld", 32'(res_vld), 0);
    rdy_in = 1'b1;
    for (int i = 0; i < N; i++) offer_rand(i);
    step();
    check("midrst_first_grant", 32'(act_rdy), 1);
    drain(4);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 99) < 40) offer_rand(i);
        end else if ($urandom_range(0, 99) < 3) begin
          pend[i] = 1'b0;
        end
      end
      rdy_in = ($urandom_range(0, 3) != 0);
      rst_in = ($urandom_range(0, 499) == 0);
      step();
    end
    rst_in = 1'b0;
    drain(4);
    check("drain_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sat_add_arbiter.md
Name: sat_add_arbiter

Overview:
- Shares one signed saturating adder among N_REQ requesters using round-robin arbitration.
- Each requester offers an operand pair through a valid/ready handshake.
- The granted pair is added with saturation and registered into a single output stage, tagged with the requester index.
- Sits between several producer streams and one downstream consumer of saturated sums.

Parameters:
N_REQ, 4, number of requesters (2..16)
W, 4, operand/result width, two's complement signed
ID_W, $clog2(N_REQ), width of the requester tag (derived, not overridden)

Ports:
clk  input  1  clock
rst  input  1  reset
req_vld  input  N_REQ  per-requester operand valid
req_rdy  output  N_REQ  per-requester grant/accept; one-hot or zero
req_a  input  N_REQ*W  packed operand a; requester i at [i*W +: W]
req_b  input  N_REQ*W  packed operand b; same packing
res_vld  output  1  result valid
res_rdy  input  1  downstream accepts result
res_id  output  ID_W  index of requester that produced the result
res_sum  output  W  saturated sum
res_sat  output  1  1 when the result was clamped

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All state updates occur on posedge clk.
- Reset values: res_vld=0, res_id=0, res_sum=0, res_sat=0, round-robin pointer=0 (requester 0 has highest priority).
- A reset mid-operation drops any held result. Requesters must re-present their operands.
- Output stage state: "free" when res_vld=0 or res_rdy=1 in the current cycle.
- Grant logic is combinational:
  - If the stage is free and any req_vld is set, grant the first set req_vld searching from the pointer upward, wrapping modulo N_REQ.
  - req_rdy[g]=1 for the granted index only; all other bits are 0.
  - If the stage is not free, req_rdy=0.
- Handshake: a transfer occurs when req_vld[i] && req_rdy[i].
  - Next cycle: res_vld=1, res_id=i, res_sum and res_sat from that pair.
  - Latency is 1 cycle. Throughput is 1 result/cycle when res_rdy is held at 1.
- Pointer update: on a transfer from requester g, pointer <= (g+1) mod N_REQ. It is unchanged otherwise.
- Output hold: while res_vld=1 and res_rdy=0, res_id, res_sum and res_sat are held stable.
- Output drain: if res_rdy=1 and no transfer occurs in the same cycle, res_vld <= 0.
- Simultaneous events: res_rdy=1 and a new transfer in the same cycle load the new result with no bubble.
- Arithmetic:
  - Sign-extend a and b to W+2 bits and add exactly.
  - If sum > 2^(W-1)-1: res_sum = max positive (0111 for W=4), res_sat=1.
  - If sum < -2^(W-1): res_sum = min negative (1000), res_sat=1.
  - Otherwise res_sum = low W bits, res_sat=0.
- Requester obligations: a requester holds req_vld, req_a and req_b stable until accepted. The block does not check this.
- A requester that drops req_vld before grant is simply skipped.
- Idle: with no req_vld set, the pointer is unchanged and no transfer occurs.

Optional Feature:
- Macro: SAT_ADD_ARB_SAT_CNT_EN.
- When defined:
  - Adds output port sat_cnt, 16 bits, reset to 0.
  - Increments by 1 on each output handshake (res_vld && res_rdy) where res_sat=1.
  - Sticks at 16'hFFFF; does not wrap.
- When undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then all four req_vld=1 with res_rdy=1 held -> grants in order 0,1,2,3,0,1.
  - One result per cycle; res_id follows the same sequence one cycle later.
- Saturation via requester 0, W=4:
  - (4,7) -> res_sum=7, res_sat=1
  - (-4,-7) -> -8, sat=1
  - (3,-5) -> -2, sat=0
  - (-3,-6) -> -8, sat=1
  - (4,-4) -> 0, sat=0
- Backpressure:
  - Requester 1 sends (1,2) and is accepted.
  - res_rdy=0 for 3 cycles -> res_vld=1, res_sum=3, res_id=1 held; req_rdy=0 throughout.
  - res_rdy=1 -> the next pending request is granted in the same cycle.
- Fairness and skip:
  - Only req_vld[2] set, continuously -> req_rdy[2]=1 every cycle, back-to-back results.
  - Then req_vld[0] and req_vld[2] both set, pointer at 3 -> grant 0 then 2, alternating.
- Reset mid-operation: rst=1 while res_vld=1 and res_rdy=0 -> next cycle res_vld=0, pointer=0.
  - With all req_vld set after reset, the first grant is requester 0.
- With SAT_ADD_ARB_SAT_CNT_EN:
  - Five saturating and two non-saturating results accepted -> sat_cnt=5.
  - A saturating result held with res_rdy=0 does not increment sat_cnt until accepted.
